// File: rtl/pcileech_pcie_tlp_tx_arb_pkg.sv
// Shared types for the PCIe TX arbiter: FSM state encoding and the 64-bit beat carried
// through the output/skid registers.
package pcileech_pcie_tlp_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } tlp_beat_t;

endpackage

// File: rtl/pcileech_axis_skid64.sv
// Output register plus skid register for the 64-bit TX stream; in_ready depends only on
// registered skid occupancy, so there is no combinational path from out_ready.
module pcileech_axis_skid64
  import pcileech_pcie_tlp_tx_arb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  tlp_beat_t in_beat,
  input  logic      in_valid,
  output logic      in_ready,
  output tlp_beat_t out_beat,
  output logic      out_valid,
  input  logic      out_ready,
  output logic      skid_full
);

  tlp_beat_t out_q, out_d, skid_q, skid_d;
  logic      out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic      accept;

  assign accept = in_valid & ~skid_vld_q;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || out_ready) begin
      // Skid drains first; input is blocked while skid is full, so no beat is lost.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_d     = accept ? in_beat : out_q;
        out_vld_d = accept;
      end
    end else if (accept) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign in_ready  = ~skid_vld_q;
  assign out_beat  = out_q;
  assign out_valid = out_vld_q;
  assign skid_full = skid_vld_q;

endmodule

// File: rtl/pcileech_pcie_tlp_tx_arb.sv
// Packet-atomic round-robin arbiter of two TLP sources onto the PCIe core TX stream.
// Optional start gating on tx_buf_av is compiled in with PCILEECH_TX_BUFAV_GATE_EN.
module pcileech_pcie_tlp_tx_arb
  import pcileech_pcie_tlp_tx_arb_pkg::*;
#(
  parameter logic [5:0] BUFAV_MIN = 6'd2
) (
  input  logic        clk_pcie,
  input  logic        rst,
  input  logic [63:0] s0_data,
  input  logic [7:0]  s0_keep,
  input  logic        s0_last,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [63:0] s1_data,
  input  logic [7:0]  s1_keep,
  input  logic        s1_last,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [5:0]  tx_buf_av,
  input  logic        tx_err_drop,
  output logic [63:0] m_data,
  output logic [7:0]  m_keep,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  arb_state_e state_q, state_d;
  logic       last1_q, last1_d;   // 1: s1 was served last, so s0 wins the next tie
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic       start_ok, skid_in_ready, skid_full;
  tlp_beat_t  in_beat, out_beat;
  logic       in_valid;

`ifdef PCILEECH_TX_BUFAV_GATE_EN
  assign start_ok = (tx_buf_av >= BUFAV_MIN);
`else
  logic unused_bufav;
  assign unused_bufav = ^{tx_buf_av, BUFAV_MIN};
  assign start_ok     = 1'b1;
`endif

  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last1_q    <= 1'b1;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last1_q    <= last1_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last1_d = last1_q;
    case (state_q)
      ST_IDLE: if (start_ok) begin
        if (s0_valid && (!s1_valid || last1_q)) state_d = ST_GNT0;
        else if (s1_valid)                      state_d = ST_GNT1;
      end
      ST_GNT0: if (s0_valid && s0_ready && s0_last) begin
        state_d = ST_IDLE;
        last1_d = 1'b0;
      end
      ST_GNT1: if (s1_valid && s1_ready && s1_last) begin
        state_d = ST_IDLE;
        last1_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s0_ready = (state_q == ST_GNT0) & skid_in_ready;
    s1_ready = (state_q == ST_GNT1) & skid_in_ready;
    if (state_q == ST_GNT1) begin
      in_beat  = '{data: s1_data, keep: s1_keep, last: s1_last};
      in_valid = s1_valid & s1_ready;
    end else begin
      in_beat  = '{data: s0_data, keep: s0_keep, last: s0_last};
      in_valid = s0_valid & s0_ready;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (tx_err_drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  pcileech_axis_skid64 u_skid (
    .clk       (clk_pcie),
    .rst       (rst),
    .in_beat   (in_beat),
    .in_valid  (in_valid),
    .in_ready  (skid_in_ready),
    .out_beat  (out_beat),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .skid_full (skid_full)
  );

  assign m_data   = out_beat.data;
  assign m_keep   = out_beat.keep;
  assign m_last   = out_beat.last;
  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != ST_IDLE) | m_valid | skid_full;

endmodule

// File: tb/tb_pcileech_pcie_tlp_tx_arb.sv
// Directed bench for the TX arbiter: per-scenario tasks, expected beats built by hand.
module tb_pcileech_pcie_tlp_tx_arb;
  import pcileech_pcie_tlp_tx_arb_pkg::*;

  logic clk_pcie = 1'b0;
  logic rst = 1'b1;
  logic [63:0] s0_data = '0, s1_data = '0, m_data;
  logic [7:0]  s0_keep = '0, s1_keep = '0, m_keep;
  logic s0_last = 0, s0_valid = 0, s0_ready, s1_last = 0, s1_valid = 0, s1_ready;
  logic [5:0] tx_buf_av = 6'd32;
  logic tx_err_drop = 0, m_last, m_valid, m_ready = 1'b1, busy;
  logic [15:0] drop_cnt;

  int vec = 0, errs = 0;
  tlp_beat_t q0[$], q1[$], out_q[$], held, tmp;
  logic rdy_mode = 0, stalled = 0;
  int rdy_cnt = 0, stall_err = 0;

  always #5 clk_pcie = ~clk_pcie;

  pcileech_pcie_tlp_tx_arb dut (
    .clk_pcie(clk_pcie), .rst(rst),
    .s0_data(s0_data), .s0_keep(s0_keep), .s0_last(s0_last), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_keep(s1_keep), .s1_last(s1_last), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .tx_buf_av(tx_buf_av), .tx_err_drop(tx_err_drop),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  // Bus process: drive sources and m_ready at negedge, record handshakes 1ns later.
  initial begin
    forever begin
      @(negedge clk_pcie);
      m_ready = rdy_mode ? (rdy_cnt % 3 == 0) : 1'b1;
      rdy_cnt++;
      if (q0.size() > 0) begin
        s0_valid = 1; s0_data = q0[0].data; s0_keep = q0[0].keep; s0_last = q0[0].last;
      end else s0_valid = 0;
      if (q1.size() > 0) begin
        s1_valid = 1; s1_data = q1[0].data; s1_keep = q1[0].keep; s1_last = q1[0].last;
      end else s1_valid = 0;
      #1;
      if (s0_valid && s0_ready) tmp = q0.pop_front();
      if (s1_valid && s1_ready) tmp = q1.pop_front();
      if (rst) stalled = 0;
      else begin
        if (stalled && (m_valid !== 1'b1 || m_data !== held.data || m_keep !== held.keep || m_last !== held.last))
          stall_err++;
        stalled = m_valid & ~m_ready;
        held = '{data: m_data, keep: m_keep, last: m_last};
        if (m_valid && m_ready) out_q.push_back(held);
      end
    end
  end

  function automatic tlp_beat_t mk(input logic [63:0] d, input logic [7:0] k, input logic l);
    mk = '{data: d, keep: k, last: l};
  endfunction

  task automatic do_reset();
    rst = 1; q0.delete(); q1.delete(); rdy_mode = 0;
    repeat (2) @(negedge clk_pcie);
    #3 rst = 0; out_q.delete();
  endtask

  task automatic check_beats(input string nm, input tlp_beat_t exp[$]);
    // only compares the captured stream against an expected list; called by scenario tasks
    vec++;
    if (out_q.size() !== exp.size()) begin
      errs++; $display("FAIL %s count: got %0d want %0d", nm, out_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < out_q.size(); i++) begin
      vec++;
      if (out_q[i] !== exp[i]) begin
        errs++; $display("FAIL %s beat%0d: got %h/%h/%b want %h/%h/%b", nm, i,
          out_q[i].data, out_q[i].keep, out_q[i].last, exp[i].data, exp[i].keep, exp[i].last);
      end
    end
  endtask

  task automatic wait_out(input string nm, input int n);
    int k;
    for (k = 0; k < 100 && out_q.size() < n; k++) begin @(negedge clk_pcie); #3; end
    if (out_q.size() < n) begin
      vec++; errs++; $display("FAIL %s timeout: got %0d beats want %0d", nm, out_q.size(), n);
    end
    repeat (4) @(negedge clk_pcie);
    #3;
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk_pcie); #3;
    vec++; if ({m_valid, m_last, s0_ready, s1_ready, busy} !== 5'b0) begin
      errs++; $display("FAIL reset_ctl: got %b want 00000", {m_valid, m_last, s0_ready, s1_ready, busy}); end
    vec++; if (m_data !== 64'h0) begin errs++; $display("FAIL reset_data: got %h want 0", m_data); end
    vec++; if (m_keep !== 8'h0) begin errs++; $display("FAIL reset_keep: got %h want 0", m_keep); end
    vec++; if (drop_cnt !== 16'h0) begin errs++; $display("FAIL reset_drop: got %h want 0", drop_cnt); end
  endtask

  task automatic test_basic();
    tlp_beat_t exp[3];
    do_reset();
    exp[0] = mk(64'hA0A0_0000_0000_0001, 8'hFF, 0);
    exp[1] = mk(64'hA0A0_0000_0000_0002, 8'hFF, 0);
    exp[2] = mk(64'hA0A0_0000_0000_0003, 8'h0F, 1);
    for (int i = 0; i < 3; i++) q0.push_back(exp[i]);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_pcie); #3;
      vec++;
      if (s1_ready !== 1'b0) begin errs++; $display("FAIL basic_s1rdy c%0d: got %b want 0", c, s1_ready); end
      vec++;
      if (m_valid !== (c >= 2 && c <= 4)) begin
        errs++; $display("FAIL basic_valid c%0d: got %b want %b", c, m_valid, (c >= 2 && c <= 4));
      end else if (c >= 2 && c <= 4) begin
        vec++;
        if (m_data !== exp[c-2].data || m_keep !== exp[c-2].keep || m_last !== exp[c-2].last) begin
          errs++; $display("FAIL basic_beat c%0d: got %h/%h/%b want %h/%h/%b", c, m_data, m_keep, m_last,
            exp[c-2].data, exp[c-2].keep, exp[c-2].last);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    tlp_beat_t exp[$];
    rst = 1; q0.delete(); q1.delete(); rdy_mode = 0;
    for (int t = 0; t < 2; t++)
      for (int b = 0; b < 2; b++) begin
        q0.push_back(mk(64'h5000_0000_0000_0000 | 64'(t * 16 + b), 8'hFF, b == 1));
        q1.push_back(mk(64'h5000_0000_0000_0100 | 64'(t * 16 + b), 8'hFF, b == 1));
      end
    repeat (2) @(negedge clk_pcie);
    #3 rst = 0; out_q.delete();
    for (int t = 0; t < 2; t++)
      for (int s = 0; s < 2; s++)
        for (int b = 0; b < 2; b++)
          exp.push_back(mk(64'h5000_0000_0000_0000 | 64'(s * 256 + t * 16 + b), 8'hFF, b == 1));
    wait_out("rr", 8);
    check_beats("rr", exp);
  endtask

  task automatic test_stall();
    tlp_beat_t exp[$];
    do_reset();
    rdy_cnt = 0; rdy_mode = 1; stall_err = 0;
    for (int b = 0; b < 4; b++) exp.push_back(mk(64'hC1C1_0000_0000_0010 + 64'(b), 8'hF0 | 8'(b), b == 3));
    foreach (exp[i]) q1.push_back(exp[i]);
    wait_out("stall", 4);
    check_beats("stall", exp);
    vec++; if (stall_err !== 0) begin errs++; $display("FAIL stall_hold: got %0d changes want 0", stall_err); end
    rdy_mode = 0;
  endtask

  task automatic test_gate();
    tlp_beat_t exp[$];
    do_reset();
    exp.push_back(mk(64'h6A7E_0000_0000_0001, 8'hFF, 0));
    exp.push_back(mk(64'h6A7E_0000_0000_0002, 8'h03, 1));
`ifdef PCILEECH_TX_BUFAV_GATE_EN
    tx_buf_av = 6'd1;
    foreach (exp[i]) q1.push_back(exp[i]);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_pcie); #3;
      vec++; if (s1_ready !== 1'b0 || busy !== 1'b0) begin
        errs++; $display("FAIL gate_hold c%0d: got rdy=%b busy=%b want 0 0", c, s1_ready, busy); end
    end
    tx_buf_av = 6'd2;
    @(negedge clk_pcie); #3;
    vec++; if (s1_ready !== 1'b1) begin errs++; $display("FAIL gate_open: got %b want 1", s1_ready); end
`else
    tx_buf_av = 6'd0;
    foreach (exp[i]) q1.push_back(exp[i]);
    @(negedge clk_pcie); #3;
    vec++; if (s1_ready !== 1'b0) begin errs++; $display("FAIL nogate_c0: got %b want 0", s1_ready); end
    @(negedge clk_pcie); #3;
    vec++; if (s1_ready !== 1'b1) begin errs++; $display("FAIL nogate_c1: got %b want 1", s1_ready); end
`endif
    wait_out("gate", 2);
    check_beats("gate", exp);
    tx_buf_av = 6'd32;
  endtask

  task automatic test_reset_mid();
    tlp_beat_t exp[$];
    int k;
    do_reset();
    for (int b = 0; b < 4; b++) q0.push_back(mk(64'hDEAD_0000_0000_0000 + 64'(b), 8'hFF, b == 3));
    for (k = 0; k < 40 && out_q.size() < 2; k++) begin @(negedge clk_pcie); #3; end
    vec++; if (out_q.size() < 2) begin errs++; $display("FAIL rstmid_start: got %0d beats want 2", out_q.size()); end
    rst = 1; q0.delete();
    @(negedge clk_pcie); #3;
    vec++; if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL rstmid_clear: got valid=%b busy=%b want 0 0", m_valid, busy); end
    rst = 0; out_q.delete();
    for (int b = 0; b < 3; b++) exp.push_back(mk(64'hF00D_0000_0000_0000 + 64'(b), 8'h3F, b == 2));
    foreach (exp[i]) q0.push_back(exp[i]);
    wait_out("rstmid", 3);
    check_beats("rstmid", exp);
  endtask

  task automatic test_drop_sat();
    do_reset();
    tx_err_drop = 1;
    repeat (5) @(negedge clk_pcie);
    #3;
    vec++; if (drop_cnt !== 16'd5) begin errs++; $display("FAIL drop_5: got %h want 0005", drop_cnt); end
    repeat (65530) @(negedge clk_pcie);
    #3;
    vec++; if (drop_cnt !== 16'hFFFF) begin errs++; $display("FAIL drop_ffff: got %h want ffff", drop_cnt); end
    repeat (3) @(negedge clk_pcie);
    #3 tx_err_drop = 0;
    vec++; if (drop_cnt !== 16'hFFFF) begin errs++; $display("FAIL drop_sat: got %h want ffff", drop_cnt); end
    repeat (2) @(negedge clk_pcie);
    #3;
    vec++; if (drop_cnt !== 16'hFFFF) begin errs++; $display("FAIL drop_hold: got %h want ffff", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_gate();
    test_reset_mid();
    test_drop_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
